cdc_handshake_rx: RTL and testbench
===================================

// Module: cdc_handshake_rx
//
// PURPOSE
//   Receive side of a toggle-handshake clock-domain crossing.
//   - The sender lives in a foreign clock domain. It presents a multi-bit word, holds it stable, then flips req_toggle_i.
//   - This block synchronizes req_toggle_i through an internal flop chain, captures the word, and offers it downstream as valid/ready.
//   - After the consumer accepts the word, it flips ack_toggle_o back to the sender.
//   - Used wherever the MCU/SPI domain hands register writes to the system clock domain.
//
// PARAMETERS
//   DATA_WIDTH   8  width of data_i/data_o
//   SYNC_STAGES  2  flops in req synchronizer chain; legal range 2..4
//
// PORTS
//   clock_i       in   1           destination clock; all logic on posedge
//   reset_n_i     in   1           synchronous, active-low reset
//   req_toggle_i  in   1           async request toggle from sender domain
//   data_i        in   DATA_WIDTH  sender word; stable from req toggle until ack toggle
//   data_o        out  DATA_WIDTH  captured word
//   valid_o       out  1           data_o holds an unaccepted word
//   ready_i       in   1           consumer accepts data_o when valid_o & ready_i
//   ack_toggle_o  out  1           toggles once per accepted word; returns to sender
//   err_o         out  1           sticky protocol-violation flag
//
// BEHAVIOUR
//   Reset (reset_n_i==0 at posedge):
//   - sync chain=0, req_seen=0, state=IDLE, data_o=0, valid_o=0, ack_toggle_o=0, err_o=0.
//   - Reset mid-transfer drops the word; no ack is issued.
//   - Sender must be reset together with this block. If req_toggle_i is 1 after reset, that is a pending request and it is serviced.
//   Sync chain:
//   - SYNC_STAGES flops shift req_toggle_i; req_sync is the last stage.
//   - Only req_sync is used; req_toggle_i never feeds other logic.
//   req_seen: level of req_sync at the last capture.
//   FSM states: IDLE, HOLD.
//   - IDLE: if req_sync != req_seen, then at that edge: data_o<=data_i, valid_o<=1, req_seen<=req_sync, go to HOLD. Otherwise stay.
//   - HOLD: valid_o stays 1 and data_o stays stable.
//     - On valid_o & ready_i: valid_o<=0, ack_toggle_o<=~ack_toggle_o, go to IDLE.
//     - ready_i without valid_o is ignored.
//   - Protocol violation: in HOLD, req_sync != req_seen (sender toggled again before ack).
//     - Sets err_o=1 until reset.
//     - Current word is kept; the new toggle is serviced after return to IDLE (req_sync still differs).
//   Latency:
//   - req_toggle_i flips before edge 0 (setup met). valid_o=1 after edge SYNC_STAGES.
//   - Acceptance at edge A gives ack_toggle_o flipped and valid_o=0 after edge A.
//   - ready_i held high: back-to-back words need >= SYNC_STAGES+1 cycles apart in this domain, plus sender-side ack sync.
//   Simultaneous events:
//   - Accept in HOLD with a new req toggle in the same cycle: accept completes and err_o sets.
//   - Accept-and-capture never happen in one cycle; capture is only from IDLE.
//   Width: data path is a pure register, no arithmetic. ack_toggle_o is a single registered flop (glitch-free for the sender's synchronizer).
//
// TESTING
//   1. Reset with req_toggle_i=0, then no toggle for 20 clocks -> valid_o=0, ack_toggle_o=0, err_o=0 throughout.
//   2. data_i=8'hA5, flip req 0->1 before edge 0, ready_i=1 -> valid_o=1 and data_o=8'hA5 after edge 2. ack_toggle_o=1 after edge 3. valid_o=0 after edge 3.
//   3. Same as 2 but ready_i=0 for 10 clocks -> valid_o and data_o=8'hA5 hold. ack_toggle_o stays 0 until ready_i rises, then flips on that edge.
//   4. Sender sends 8'h01, 8'h02, 8'h03, each toggling only after seeing ack flip, ready_i=1 -> three accepts in order, ack_toggle_o ends at 1, err_o=0.
//   5. While in HOLD with word 8'h11, flip req again with data 8'h22 -> err_o=1 (sticky). 8'h11 accepted first, then 8'h22 delivered.
//   6. Assert reset_n_i=0 one clock while in HOLD -> valid_o=0, ack_toggle_o=0, err_o=0 next edge. Req level 1 after release causes one new capture.

Source files
------------

// File: rtl/cdc_handshake_rx.sv
// cdc_handshake_rx
//   Receive side of a toggle-handshake clock-domain crossing. The sender flips
//   req_toggle_i after presenting a stable word. The toggle is synchronized into
//   this domain, the word is captured and offered downstream as valid/ready, and
//   ack_toggle_o flips once the consumer takes it.
//
// Ports
//   clock_i       in   destination clock, all logic on posedge
//   reset_n_i     in   synchronous active-low reset
//   req_toggle_i  in   asynchronous request toggle from the sender domain
//   data_i        in   sender word, stable from req toggle until ack toggle
//   data_o        out  captured word
//   valid_o       out  data_o holds an unaccepted word
//   ready_i       in   consumer accepts data_o when valid_o & ready_i
//   ack_toggle_o  out  toggles once per accepted word, returns to the sender
//   err_o         out  sticky flag: sender toggled again before being acked
//
// SYNC_STAGES must be in 2..4.

module cdc_handshake_rx #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  req_toggle_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  ack_toggle_o,
   output logic                  err_o
);

   localparam logic StIdle = 1'b0;
   localparam logic StHold = 1'b1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_sync;
   logic                   req_seen_q, req_seen_d;
   logic                   state_q, state_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic                   req_pending;

   // Only the last stage is ever looked at; req_toggle_i feeds nothing else.
   assign req_sync    = sync_q[SYNC_STAGES-1];
   assign req_pending = (req_sync != req_seen_q);

   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      data_d     = data_q;
      valid_d    = valid_q;
      ack_d      = ack_q;
      err_d      = err_q;
      case (state_q)
         StIdle: begin
            // Capture only from idle, so accept and capture never share a cycle.
            if (req_pending) begin
               data_d     = data_i;
               valid_d    = 1'b1;
               req_seen_d = req_sync;
               state_d    = StHold;
            end
         end
         StHold: begin
            // A second toggle before ack is flagged; req_seen is left alone so the
            // new request is picked up once we are back in idle.
            if (req_pending) begin
               err_d = 1'b1;
            end
            if (valid_q && ready_i) begin
               valid_d = 1'b0;
               ack_d   = ~ack_q;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         sync_q     <= '0;
         req_seen_q <= 1'b0;
         state_q    <= StIdle;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], req_toggle_i};
         req_seen_q <= req_seen_d;
         state_q    <= state_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign ack_toggle_o = ack_q;  // straight from a flop, glitch-free for the sender
   assign err_o        = err_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
module tb_cdc_handshake_rx;

   logic       clock_i = 1'b0;
   logic       reset_n_i;
   logic       req_toggle_i;
   logic [7:0] data_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       ack_toggle_o;
   logic       err_o;

   int total = 0;
   int bad = 0;
   int accepts = 0;
   logic [7:0] sb_q[$];
   logic [7:0] exp_word;

   cdc_handshake_rx #(
      .DATA_WIDTH (8),
      .SYNC_STAGES(2)
   ) dut (
      .clock_i     (clock_i),
      .reset_n_i   (reset_n_i),
      .req_toggle_i(req_toggle_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .ack_toggle_o(ack_toggle_o),
      .err_o       (err_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One destination edge; outputs sampled 1 ns later, inputs driven after that.
   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      int n = 0;
      while (!valid_o && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, {31'd0, valid_o}, 32'd1);
   endtask

   task automatic wait_ack(input string tag, input logic level, input int max_cycles);
      int n = 0;
      while (ack_toggle_o !== level && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, {31'd0, ack_toggle_o}, {31'd0, level});
   endtask

   task automatic send(input logic [7:0] w);
      data_i       = w;
      req_toggle_i = ~req_toggle_i;
      sb_q.push_back(w);
   endtask

   // Scoreboard: inputs are stable at the falling edge, so a handshake seen here
   // is the one the next rising edge accepts.
   always @(negedge clock_i) begin
      if (reset_n_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", {24'd0, data_o}, 32'hFFFF_FFFF);
         end else begin
            exp_word = sb_q.pop_front();
            check("sb_data", {24'd0, data_o}, {24'd0, exp_word});
            accepts++;
         end
      end
   end

   initial begin
      reset_n_i    = 1'b0;
      req_toggle_i = 1'b0;
      data_i       = 8'h00;
      ready_i      = 1'b0;
      repeat (3) tick();
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_data", {24'd0, data_o}, 32'd0);
      check("rst_ack", {31'd0, ack_toggle_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      reset_n_i = 1'b1;

      // 1: idle for 20 clocks
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_quiet", {29'd0, valid_o, ack_toggle_o, err_o}, 32'd0);
      end

      // 2: single word, ready held high
      ready_i = 1'b1;
      send(8'hA5);
      tick();  // edge 0
      check("t2_e0_valid", {31'd0, valid_o}, 32'd0);
      tick();  // edge 1
      check("t2_e1_valid", {31'd0, valid_o}, 32'd0);
      tick();  // edge 2
      check("t2_e2_valid", {31'd0, valid_o}, 32'd1);
      check("t2_e2_data", {24'd0, data_o}, 32'hA5);
      check("t2_e2_ack", {31'd0, ack_toggle_o}, 32'd0);
      tick();  // edge 3
      check("t2_e3_valid", {31'd0, valid_o}, 32'd0);
      check("t2_e3_ack", {31'd0, ack_toggle_o}, 32'd1);

      // 3: consumer stalls for 10 clocks
      ready_i = 1'b0;
      send(8'hA5);
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", {31'd0, valid_o}, 32'd1);
         check("t3_hold_data", {24'd0, data_o}, 32'hA5);
         check("t3_hold_ack", {31'd0, ack_toggle_o}, 32'd1);
         tick();
      end
      ready_i = 1'b1;
      tick();
      check("t3_ack_flip", {31'd0, ack_toggle_o}, 32'd0);
      check("t3_valid_drop", {31'd0, valid_o}, 32'd0);

      // 4: three words, each sent only after the previous ack
      send(8'h01);
      wait_ack("t4_ack1", 1'b1, 20);
      send(8'h02);
      wait_ack("t4_ack2", 1'b0, 20);
      send(8'h03);
      wait_ack("t4_ack3", 1'b1, 20);
      check("t4_ack_end", {31'd0, ack_toggle_o}, 32'd1);
      check("t4_err", {31'd0, err_o}, 32'd0);
      check("t4_accepts", accepts, 32'd5);

      // 5: sender toggles again while word is held
      ready_i = 1'b0;
      send(8'h11);
      wait_valid("t5_valid11", 10);
      send(8'h22);
      repeat (3) tick();
      check("t5_err", {31'd0, err_o}, 32'd1);
      check("t5_keep_valid", {31'd0, valid_o}, 32'd1);
      check("t5_keep_data", {24'd0, data_o}, 32'h11);
      ready_i = 1'b1;
      wait_ack("t5_ack11", 1'b0, 10);
      wait_ack("t5_ack22", 1'b1, 20);
      check("t5_err_sticky", {31'd0, err_o}, 32'd1);
      check("t5_accepts", accepts, 32'd7);

      // 6: reset while holding a word
      ready_i = 1'b0;
      send(8'h77);
      wait_valid("t6_valid77", 10);
      reset_n_i = 1'b0;
      tick();
      check("t6_rst_valid", {31'd0, valid_o}, 32'd0);
      check("t6_rst_ack", {31'd0, ack_toggle_o}, 32'd0);
      check("t6_rst_err", {31'd0, err_o}, 32'd0);
      sb_q.delete();  // the held word is dropped
      data_i       = 8'h5C;
      req_toggle_i = 1'b1;
      sb_q.push_back(8'h5C);
      reset_n_i = 1'b1;
      ready_i   = 1'b1;
      wait_valid("t6_recapture", 10);
      check("t6_data", {24'd0, data_o}, 32'h5C);
      wait_ack("t6_ack", 1'b1, 10);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t6_no_extra", {31'd0, valid_o}, 32'd0);
      end
      check("final_accepts", accepts, 32'd8);
      check("final_sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
